// File: rtl/drink_dispense_ctrl.sv
// Drink order sequencer: accepts one order, pours for size*POUR_MS, then settles before the next order.
// Optional build macro DISPENSE_COUNT_EN adds pour_count, the per-drink count of completed pours.
module drink_dispense_ctrl #(
   parameter int TICKS_PER_MS = 100000,
   parameter int POUR_MS      = 1000,
   parameter int SETTLE_MS    = 300
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        order_valid,
   input  logic [1:0]  order_drink,
   input  logic [1:0]  order_size,
   output logic        order_ready,
   output logic        enable,
   output logic [1:0]  which_drink,
   output logic        busy,
   output logic        done,
   output logic        err
`ifdef DISPENSE_COUNT_EN
   ,
   output logic [23:0] pour_count
`endif
);

   localparam int TICK_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam int MS_MAX = (3 * POUR_MS > SETTLE_MS) ? 3 * POUR_MS : SETTLE_MS;
   localparam int MS_W   = $clog2(MS_MAX + 1);
   localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICKS_PER_MS - 1);
   localparam logic [MS_W-1:0]   SETTLE_LAST = MS_W'(SETTLE_MS - 1);
   localparam logic [MS_W-1:0]   POUR_UNIT   = MS_W'(POUR_MS);

   typedef enum logic [1:0] {S_IDLE, S_OPEN, S_SETTLE, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [TICK_W-1:0] r_tick;
   logic [MS_W-1:0]   r_ms;
   logic [1:0]        r_size;

   logic              w_accept;
   logic              w_order_ok;
   logic              w_ms_wrap;
   logic [MS_W-1:0]   w_pour_last;
   logic              w_enable_d;
   logic              w_busy_d;
   logic              w_ready_d;
   logic              w_done_d;
   logic              w_err_d;
   logic [1:0]        w_which_d;

   assign w_accept    = order_valid && order_ready;
   assign w_order_ok  = (order_drink != 2'd3) && (order_size != 2'd0);
   assign w_ms_wrap   = (r_tick == TICK_LAST);
   assign w_pour_last = MS_W'(r_size) * POUR_UNIT - MS_W'(1);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_accept && w_order_ok) w_next_state = S_OPEN;
         S_OPEN:   if (w_ms_wrap && (r_ms == w_pour_last)) w_next_state = S_SETTLE;
         S_SETTLE: if (w_ms_wrap && (r_ms == SETTLE_LAST)) w_next_state = S_DONE;
         S_DONE:   w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they line up with the state.
   always_comb begin
      w_enable_d = (w_next_state == S_OPEN);
      w_busy_d   = (w_next_state != S_IDLE);
      w_ready_d  = (w_next_state == S_IDLE);
      w_done_d   = (w_next_state == S_DONE);
      w_err_d    = (r_state == S_IDLE) && w_accept && !w_order_ok;
      w_which_d  = which_drink;
      if ((r_state == S_IDLE) && w_accept && w_order_ok) w_which_d = order_drink;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         order_ready <= 1'b1;
         enable      <= 1'b0;
         which_drink <= 2'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         r_size      <= 2'd0;
      end else begin
         order_ready <= w_ready_d;
         enable      <= w_enable_d;
         which_drink <= w_which_d;
         busy        <= w_busy_d;
         done        <= w_done_d;
         err         <= w_err_d;
         if ((r_state == S_IDLE) && w_accept && w_order_ok) r_size <= order_size;
      end
   end

   // Clearing on every state change keeps each phase exactly its nominal length.
   always_ff @(posedge clk) begin
      if (rst || (w_next_state != r_state)) begin
         r_tick <= '0;
         r_ms   <= '0;
      end else if ((r_state == S_OPEN) || (r_state == S_SETTLE)) begin
         if (w_ms_wrap) begin
            r_tick <= '0;
            r_ms   <= r_ms + MS_W'(1);
         end else begin
            r_tick <= r_tick + TICK_W'(1);
         end
      end
   end

`ifdef DISPENSE_COUNT_EN
   logic [7:0] r_cnt [3];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) r_cnt[i] <= 8'd0;
      end else if ((w_next_state == S_DONE) && (r_state != S_DONE)) begin
         for (int i = 0; i < 3; i++)
            if ((which_drink == 2'(i)) && (r_cnt[i] != 8'hFF)) r_cnt[i] <= r_cnt[i] + 8'd1;
      end
   end

   assign pour_count = {r_cnt[2], r_cnt[1], r_cnt[0]};
`endif

endmodule

// File: tb/tb_drink_dispense_ctrl.sv
// Bench for drink_dispense_ctrl: schedule-based reference model checked every cycle plus directed literal checks.
// Define DISPENSE_COUNT_EN to also exercise pour_count.
module tb_drink_dispense_ctrl;
   localparam int TPM = 10;
   localparam int PMS = 5;
   localparam int SMS = 3;
   localparam int SETTLE_CYC = SMS * TPM;

   logic       clk;
   logic       rst;
   logic       order_valid;
   logic [1:0] order_drink;
   logic [1:0] order_size;
   logic       order_ready;
   logic       enable;
   logic [1:0] which_drink;
   logic       busy;
   logic       done;
   logic       err;
`ifdef DISPENSE_COUNT_EN
   logic [23:0] pour_count;
`endif

   drink_dispense_ctrl #(.TICKS_PER_MS(TPM), .POUR_MS(PMS), .SETTLE_MS(SMS)) dut (
      .clk(clk), .rst(rst), .order_valid(order_valid), .order_drink(order_drink),
      .order_size(order_size), .order_ready(order_ready), .enable(enable),
      .which_drink(which_drink), .busy(busy), .done(done), .err(err)
`ifdef DISPENSE_COUNT_EN
      , .pour_count(pour_count)
`endif
   );

   // clock / cycle counter
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // reference model: each accepted order defines a timeline relative to its handshake cycle
   bit         m_known = 0;
   bit         m_active = 0;
   bit         m_err_now = 0;
   int         m_start = 0;
   int         m_n = 0;
   logic [1:0] m_which = 2'd0;
   logic [7:0] m_cnt [3];

   always @(negedge clk) begin
      int  k;
      bit  e_en, e_busy, e_done, e_ready;
      k = cyc - m_start;
      e_en    = m_active && (k >= 1) && (k <= m_n);
      e_busy  = m_active && (k >= 1) && (k <= m_n + SETTLE_CYC + 1);
      e_done  = m_active && (k == m_n + SETTLE_CYC + 1);
      e_ready = !e_busy;
      if (m_known) begin
         if (e_done && (m_cnt[m_which] != 8'd255)) m_cnt[m_which] = m_cnt[m_which] + 8'd1;
         check("enable", 32'(enable), 32'(e_en));
         check("busy", 32'(busy), 32'(e_busy));
         check("done", 32'(done), 32'(e_done));
         check("order_ready", 32'(order_ready), 32'(e_ready));
         check("err", 32'(err), 32'(m_err_now));
         check("which_drink", 32'(which_drink), 32'(m_which));
`ifdef DISPENSE_COUNT_EN
         check("pour_count", 32'(pour_count), 32'({m_cnt[2], m_cnt[1], m_cnt[0]}));
`endif
      end
      m_err_now = 0;
      if (e_done) m_active = 0;
      if (rst) begin
         m_known = 1;
         m_active = 0;
         m_which = 2'd0;
         for (int i = 0; i < 3; i++) m_cnt[i] = 8'd0;
      end else if (m_known && e_ready && order_valid) begin
         if ((order_drink <= 2'd2) && (order_size >= 2'd1)) begin
            m_active = 1;
            m_start = cyc;
            m_n = int'(order_size) * PMS * TPM;
            m_which = order_drink;
         end else begin
            m_err_now = 1;
         end
      end
   end

   // driver tasks
   task automatic send(input logic [1:0] d, input logic [1:0] s, output int hs);
      order_drink = d;
      order_size = s;
      order_valid = 1'b1;
      hs = -1;
      for (int i = 0; i < 400 && hs < 0; i++) begin
         @(negedge clk);
         if (order_ready) hs = cyc;
      end
      if (hs < 0) check("handshake_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 order_valid = 1'b0;
   endtask

   task automatic wait_done(output int dc);
      dc = -1;
      for (int i = 0; i < 2000 && dc < 0; i++) begin
         @(negedge clk);
         if (done) dc = cyc;
      end
      if (dc < 0) check("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog at cycle %0d", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int hs, dc, en_cnt, settle_cnt, a2, d2, done_cnt;
      rst = 1'b1;
      order_valid = 1'b0;
      order_drink = 2'd0;
      order_size = 2'd0;

      // 1: reset
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(order_ready), 32'd1);
      check("rst_enable", 32'(enable), 32'd0);
      check("rst_which", 32'(which_drink), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;

      // 2: drink 1, size 2
      send(2'd1, 2'd2, hs);
      en_cnt = 0;
      settle_cnt = 0;
      dc = -1;
      for (int i = 0; i < 400 && dc < 0; i++) begin
         @(negedge clk);
         if (enable) en_cnt++;
         if (busy && !enable && !done && which_drink == 2'd1) settle_cnt++;
         if (done) dc = cyc;
      end
      check("t2_open_cycles", 32'(en_cnt), 32'd100);
      check("t2_settle_cycles", 32'(settle_cnt), 32'd30);
      check("t2_latency", 32'(dc - hs), 32'd131);
      @(negedge clk);
      check("t2_done_single", 32'(done), 32'd0);
      @(posedge clk);
      #1;

      // 3: invalid orders
      send(2'd3, 2'd1, hs);
      @(negedge clk);
      check("t3_err_a", 32'(err), 32'd1);
      check("t3_which_a", 32'(which_drink), 32'd1);
      @(posedge clk);
      #1;
      send(2'd0, 2'd0, hs);
      @(negedge clk);
      check("t3_err_b", 32'(err), 32'd1);
      check("t3_enable_b", 32'(enable), 32'd0);
      @(negedge clk);
      check("t3_err_clear", 32'(err), 32'd0);
      @(posedge clk);
      #1;

      // 4: back-to-back with order_valid held high
      order_drink = 2'd2;
      order_size = 2'd1;
      order_valid = 1'b1;
      wait_done(dc);
      a2 = -1;
      @(negedge clk);
      if (order_ready) a2 = cyc;
      check("t4_accept_after_done", 32'(a2 - dc), 32'd1);
      @(posedge clk);
      #1 order_valid = 1'b0;
      @(negedge clk);
      check("t4_enable_second", 32'(enable), 32'd1);
      check("t4_which_second", 32'(which_drink), 32'd2);
      wait_done(d2);
      check("t4_latency_second", 32'(d2 - a2), 32'd81);
      @(posedge clk);
      #1;

      // 5: reset mid-pour
      send(2'd1, 2'd2, hs);
      repeat (39) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t5_enable", 32'(enable), 32'd0);
      check("t5_ready", 32'(order_ready), 32'd1);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_which", 32'(which_drink), 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("t5_no_done", 32'(done_cnt), 32'd0);
      @(posedge clk);
      #1;

`ifdef DISPENSE_COUNT_EN
      // 6: saturation of drink 0 counter
      for (int n = 0; n < 257; n++) begin
         send(2'd0, 2'd1, hs);
         wait_done(dc);
         if (n == 0) check("t6_first_count", 32'(pour_count), 32'h000001);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("t6_saturated", 32'(pour_count), 32'h0000FF);
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/drink_dispense_ctrl.md
Name: drink_dispense_ctrl

Overview:
- Order sequencer directly upstream of the servo PWM interface.
- Accepts one drink order via a valid/ready handshake and drives the servo interface's `enable` and `which_drink` inputs.
- Opens the selected valve for a timed pour, then closes it and holds the selection while the servo settles. Only then does it accept the next order.
- Prevents the PWM output from being re-routed to another channel while a servo is still open or moving.

Parameters:
- TICKS_PER_MS, 100000, clk cycles per millisecond (100 MHz clock).
- POUR_MS, 1000, valve-open time in ms per size unit.
- SETTLE_MS, 300, ms the closed-angle PWM is held on the same channel after a pour.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; one clock; reset is synchronous and active-high
- order_valid  input  1  order request present
- order_drink  input  2  drink select; 0..2 valid, 3 invalid
- order_size  input  2  pour units; 1..3 valid, 0 invalid
- order_ready  output  1  high only in IDLE
- enable  output  1  to servo interface; 1 = valve open angle
- which_drink  output  2  to servo interface; PWM channel select
- busy  output  1  high in OPEN, SETTLE and DONE
- done  output  1  one-cycle pulse at pour completion
- err  output  1  one-cycle pulse when an invalid order is consumed

Behaviour:
- **Reset** (rst sampled high on a clk edge; mid-operation reset aborts immediately):
  - state=IDLE, enable=0, which_drink=0, order_ready=1, busy=0, done=0, err=0, all counters=0.
- **States:** IDLE, OPEN, SETTLE, DONE. All outputs are registered.
- **IDLE:**
  - An order is consumed when order_valid && order_ready at a clk edge.
  - Valid order (drink<=2, size>=1):
    - Latch drink into which_drink and size into an internal register.
    - Next cycle: state=OPEN, enable=1, order_ready=0, busy=1.
  - Invalid order (drink==3 or size==0): err=1 for the next cycle only; state stays IDLE; which_drink unchanged.
  - order_valid without a handshake is ignored. Order inputs are don't-care outside IDLE.
- **Timing base:**
  - ms_tick counter runs 0..TICKS_PER_MS-1 and wraps.
  - The counter is cleared on every state entry, so durations are exact.
- **OPEN:**
  - enable=1 for exactly size*POUR_MS*TICKS_PER_MS cycles.
  - ms counter counts to size*POUR_MS-1; width covers 3*POUR_MS.
  - Then state=SETTLE.
- **SETTLE:**
  - enable=0 and which_drink held, so the closing PWM still reaches the same servo.
  - Lasts exactly SETTLE_MS*TICKS_PER_MS cycles, then state=DONE.
- **DONE:**
  - Lasts one cycle: done=1, busy=1, order_ready=0.
  - Next cycle: state=IDLE, order_ready=1, busy=0.
- **which_drink:** changes only on acceptance of a valid order; it retains the last value in IDLE.
- **Handshake latency:** from handshake edge to the first cycle of done=1 is exactly 1 + size*POUR_MS*TICKS_PER_MS + SETTLE_MS*TICKS_PER_MS cycles.
- **Back-to-back orders:** order_valid held high through DONE is accepted on the first IDLE cycle.
- **Output exclusivity:** done and err never assert in the same cycle.

Optional Feature:
- Macro: DISPENSE_COUNT_EN.
- When defined:
  - Adds output `pour_count`, 24 bits: {cnt2,cnt1,cnt0}, each an 8-bit count of completed pours per drink.
  - The selected drink's counter increments in the DONE cycle and saturates at 255.
  - Reset clears all counters.
  - Invalid orders do not count.
- When undefined: the port and counters are absent; all other behaviour is identical.

Test Plan (TICKS_PER_MS=10, POUR_MS=5, SETTLE_MS=3):
1. rst high 2 cycles, then low -> order_ready=1, enable=0, which_drink=0, busy=0, done=0, err=0.
2. Order drink=1, size=2 -> which_drink=1 and enable=1 for exactly 100 cycles, then enable=0 for 30 cycles with which_drink=1, then done pulses once; handshake-to-done latency is 131 cycles.
3. Order drink=3, size=1, then drink=0, size=0 -> err pulses once for each; enable stays 0; state stays IDLE; which_drink unchanged.
4. order_valid held high with drink=2, size=1 across two orders -> second order accepted the cycle after done; no enable=1 cycle overlaps the previous SETTLE.
5. rst asserted 40 cycles into OPEN -> next cycle enable=0, order_ready=1, busy=0; no done pulse follows.
6. With DISPENSE_COUNT_EN defined: 257 pours of drink 0 -> cnt0 saturates at 255 while cnt1=cnt2=0.
